// File: rtl/red_pitaya_fads_pkg.sv
// FADS sort sequencer shared definitions: FSM state encoding, register map, default widths.
package red_pitaya_fads_pkg;

  localparam int FADS_DW   = 14;
  localparam int FADS_CW   = 16;
  localparam int FADS_DLYW = 24;

  typedef enum logic [2:0] {
    ST_ARM   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DROP  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DELAY = 3'd4,
    ST_FIRE  = 3'd5,
    ST_HOLD  = 3'd6
  } fads_state_t;

  localparam logic [19:0] ADDR_CTRL   = 20'h00;
  localparam logic [19:0] ADDR_LOW    = 20'h04;
  localparam logic [19:0] ADDR_HIGH   = 20'h08;
  localparam logic [19:0] ADDR_MINW   = 20'h0C;
  localparam logic [19:0] ADDR_MAXW   = 20'h10;
  localparam logic [19:0] ADDR_DELAY  = 20'h14;
  localparam logic [19:0] ADDR_PULSE  = 20'h18;
  localparam logic [19:0] ADDR_HOLD   = 20'h1C;
  localparam logic [19:0] ADDR_STATUS = 20'h20;
  localparam logic [19:0] ADDR_DCNT   = 20'h24;
  localparam logic [19:0] ADDR_SCNT   = 20'h28;
  localparam logic [19:0] ADDR_LWIDTH = 20'h2C;
  localparam logic [19:0] ADDR_LPEAK  = 20'h30;

endpackage

// File: rtl/red_pitaya_fads_regs.sv
// FADS register file: bus decode, configuration registers and readback mux.
// FADS_STATS_EN adds the counter/last-droplet readback and the clr_cnt pulse.
module red_pitaya_fads_regs
  import red_pitaya_fads_pkg::*;
#(
  parameter int DW   = FADS_DW,
  parameter int CW   = FADS_CW,
  parameter int DLYW = FADS_DLYW
) (
  input  logic            adc_clk_i,
  input  logic            adc_rst_i,
  input  logic [31:0]     sys_addr,
  input  logic [31:0]     sys_wdata,
  input  logic [3:0]      sys_sel,
  input  logic            sys_wen,
  input  logic            sys_ren,
  output logic [31:0]     sys_rdata,
  output logic            sys_err,
  output logic            sys_ack,
  input  logic [2:0]      st_state,
  input  logic            st_trig,
`ifdef FADS_STATS_EN
  input  logic [31:0]     droplet_cnt,
  input  logic [31:0]     sorted_cnt,
  input  logic [CW-1:0]   last_width,
  input  logic [DW-1:0]   last_peak,
  output logic            clr_cnt,
`endif
  output logic            enable,
  output logic [DW-1:0]   low_thr,
  output logic [DW-1:0]   high_thr,
  output logic [CW-1:0]   min_w,
  output logic [CW-1:0]   max_w,
  output logic [DLYW-1:0] delay,
  output logic [CW-1:0]   pulse_len,
  output logic [CW-1:0]   holdoff
);

  logic [31:0] rd_mux;
  logic        unused_bus;

  // Byte selects and the undecoded address/data bits carry no meaning here.
  assign unused_bus = ^{sys_sel, sys_addr[31:20], sys_wdata[31:24]};
  assign sys_err    = 1'b0;

  // Readback selection; unmapped addresses return zero.
  always_comb begin
    rd_mux = '0;
    case (sys_addr[19:0])
      ADDR_CTRL:   rd_mux = {31'd0, enable};
      ADDR_LOW:    rd_mux = 32'(low_thr);
      ADDR_HIGH:   rd_mux = 32'(high_thr);
      ADDR_MINW:   rd_mux = 32'(min_w);
      ADDR_MAXW:   rd_mux = 32'(max_w);
      ADDR_DELAY:  rd_mux = 32'(delay);
      ADDR_PULSE:  rd_mux = 32'(pulse_len);
      ADDR_HOLD:   rd_mux = 32'(holdoff);
      ADDR_STATUS: rd_mux = {28'd0, st_trig, st_state};
`ifdef FADS_STATS_EN
      ADDR_DCNT:   rd_mux = droplet_cnt;
      ADDR_SCNT:   rd_mux = sorted_cnt;
      ADDR_LWIDTH: rd_mux = 32'(last_width);
      ADDR_LPEAK:  rd_mux = 32'($signed(last_peak));
`endif
      default:     rd_mux = '0;
    endcase
  end

  // Register writes, registered ack and read data.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
      enable    <= 1'b0;
      low_thr   <= '0;
      high_thr  <= '0;
      min_w     <= '0;
      max_w     <= '0;
      delay     <= '0;
      pulse_len <= CW'(1);
      holdoff   <= '0;
`ifdef FADS_STATS_EN
      clr_cnt   <= 1'b0;
`endif
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_ren) sys_rdata <= rd_mux;
`ifdef FADS_STATS_EN
      clr_cnt <= 1'b0;
`endif
      if (sys_wen) begin
        case (sys_addr[19:0])
          ADDR_CTRL: begin
            enable <= sys_wdata[0];
`ifdef FADS_STATS_EN
            clr_cnt <= sys_wdata[1];
`endif
          end
          ADDR_LOW:   low_thr   <= sys_wdata[DW-1:0];
          ADDR_HIGH:  high_thr  <= sys_wdata[DW-1:0];
          ADDR_MINW:  min_w     <= sys_wdata[CW-1:0];
          ADDR_MAXW:  max_w     <= sys_wdata[CW-1:0];
          ADDR_DELAY: delay     <= sys_wdata[DLYW-1:0];
          ADDR_PULSE: pulse_len <= sys_wdata[CW-1:0];
          ADDR_HOLD:  holdoff   <= sys_wdata[CW-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/red_pitaya_fads_sort_ctrl.sv
// FADS sort sequencer: droplet detection on ADC A, width/peak gating, flight delay,
// timed ASG trigger and refractory holdoff. FADS_STATS_EN enables the statistics counters.
module red_pitaya_fads_sort_ctrl
  import red_pitaya_fads_pkg::*;
#(
  parameter int DW   = FADS_DW,
  parameter int CW   = FADS_CW,
  parameter int DLYW = FADS_DLYW
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic [DW-1:0] adc_a_i,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack,
  output logic          sort_trig_o,
  output logic          busy_o
);

  fads_state_t state_q, state_d;

  logic signed [DW-1:0] s, peak;
  logic [CW-1:0]        width, pls_lat, hld_lat;
  logic [DLYW-1:0]      cnt;
  logic [2:0]           st_state;
  logic                 above, hit;

  logic                 enable;
  logic [DW-1:0]        low_thr, high_thr;
  logic [CW-1:0]        min_w, max_w, pulse_len, holdoff;
  logic [DLYW-1:0]      delay;

  // A length of N runs N cycles (0 treated as 1) with a count-down-to-zero counter.
  function automatic logic [DLYW-1:0] len_load(input logic [CW-1:0] n);
    return (n == '0) ? '0 : DLYW'(n - 1'b1);
  endfunction

  assign above       = s > $signed(low_thr);
  assign hit         = (width >= min_w) && (width <= max_w) && (peak < $signed(high_thr));
  assign sort_trig_o = (state_q == ST_FIRE);
  assign busy_o      = (state_q != ST_ARM) && (state_q != ST_IDLE);
  assign st_state    = state_q;

  // State register.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) state_q <= ST_ARM;
    else           state_q <= state_d;
  end

  // Next-state logic; dropping enable forces ARM from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:   if (!above) state_d = ST_IDLE;
      ST_IDLE:  if (above) state_d = ST_DROP;
      ST_DROP:  if (!above) state_d = ST_EVAL;
      ST_EVAL:  state_d = hit ? ((delay == '0) ? ST_FIRE : ST_DELAY) : ST_ARM;
      ST_DELAY: if (cnt == '0) state_d = ST_FIRE;
      ST_FIRE:  if (cnt == '0) state_d = ST_HOLD;
      ST_HOLD:  if (cnt == '0) state_d = ST_ARM;
      default:  state_d = ST_ARM;
    endcase
    if (!enable) state_d = ST_ARM;
  end

  // Input register, droplet measurement and the shared delay/pulse/holdoff counter.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      s       <= '0;
      peak    <= '0;
      width   <= '0;
      pls_lat <= '0;
      hld_lat <= '0;
      cnt     <= '0;
    end else begin
      s <= $signed(adc_a_i);
      case (state_q)
        ST_IDLE: if (state_d == ST_DROP) begin
          width <= CW'(1);
          peak  <= s;
        end
        ST_DROP: if (above) begin
          if (width != '1) width <= width + 1'b1;
          if (s > peak) peak <= s;
        end
        ST_EVAL: begin
          pls_lat <= pulse_len;
          hld_lat <= holdoff;
          // Zero delay skips DELAY, so the pulse length is loaded here directly.
          cnt     <= (delay == '0) ? len_load(pulse_len) : delay - 1'b1;
        end
        ST_DELAY: cnt <= (cnt == '0) ? len_load(pls_lat) : cnt - 1'b1;
        ST_FIRE:  cnt <= (cnt == '0) ? len_load(hld_lat) : cnt - 1'b1;
        ST_HOLD:  if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FADS_STATS_EN
  logic [31:0]   droplet_cnt, sorted_cnt;
  logic [CW-1:0] last_width;
  logic [DW-1:0] last_peak;
  logic          clr_cnt;

  // Saturating droplet/sort counters; a clear request beats a same-cycle increment.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      droplet_cnt <= '0;
      sorted_cnt  <= '0;
      last_width  <= '0;
      last_peak   <= '0;
    end else begin
      if (state_q == ST_EVAL) begin
        last_width <= width;
        last_peak  <= peak;
      end
      if (clr_cnt) begin
        droplet_cnt <= '0;
        sorted_cnt  <= '0;
      end else begin
        if ((state_q == ST_EVAL) && (droplet_cnt != '1)) droplet_cnt <= droplet_cnt + 1'b1;
        if ((state_d == ST_FIRE) && (state_q != ST_FIRE) && (sorted_cnt != '1))
          sorted_cnt <= sorted_cnt + 1'b1;
      end
    end
  end
`endif

  red_pitaya_fads_regs #(.DW(DW), .CW(CW), .DLYW(DLYW)) u_regs (
    .adc_clk_i   (adc_clk_i),
    .adc_rst_i   (adc_rst_i),
    .sys_addr    (sys_addr),
    .sys_wdata   (sys_wdata),
    .sys_sel     (sys_sel),
    .sys_wen     (sys_wen),
    .sys_ren     (sys_ren),
    .sys_rdata   (sys_rdata),
    .sys_err     (sys_err),
    .sys_ack     (sys_ack),
    .st_state    (st_state),
    .st_trig     (sort_trig_o),
`ifdef FADS_STATS_EN
    .droplet_cnt (droplet_cnt),
    .sorted_cnt  (sorted_cnt),
    .last_width  (last_width),
    .last_peak   (last_peak),
    .clr_cnt     (clr_cnt),
`endif
    .enable      (enable),
    .low_thr     (low_thr),
    .high_thr    (high_thr),
    .min_w       (min_w),
    .max_w       (max_w),
    .delay       (delay),
    .pulse_len   (pulse_len),
    .holdoff     (holdoff)
  );

endmodule

// File: tb/tb_red_pitaya_fads_sort_ctrl.sv
// Self-checking bench for red_pitaya_fads_sort_ctrl: register table, droplet table, corner sequences.
module tb_red_pitaya_fads_sort_ctrl;
  localparam int DW = 14, CW = 16, DLYW = 24;

  logic          adc_clk_i = 1'b0;
  logic          adc_rst_i = 1'b1;
  logic [DW-1:0] adc_a_i   = '0;
  logic [31:0]   sys_addr  = '0;
  logic [31:0]   sys_wdata = '0;
  logic [3:0]    sys_sel   = 4'hF;
  logic          sys_wen   = 1'b0;
  logic          sys_ren   = 1'b0;
  logic [31:0]   sys_rdata;
  logic          sys_err, sys_ack, sort_trig_o, busy_o;

  always #5 adc_clk_i = ~adc_clk_i;

  red_pitaya_fads_sort_ctrl #(.DW(DW), .CW(CW), .DLYW(DLYW)) dut (
    .adc_clk_i   (adc_clk_i),
    .adc_rst_i   (adc_rst_i),
    .adc_a_i     (adc_a_i),
    .sys_addr    (sys_addr),
    .sys_wdata   (sys_wdata),
    .sys_sel     (sys_sel),
    .sys_wen     (sys_wen),
    .sys_ren     (sys_ren),
    .sys_rdata   (sys_rdata),
    .sys_err     (sys_err),
    .sys_ack     (sys_ack),
    .sort_trig_o (sort_trig_o),
    .busy_o      (busy_o)
  );

  // Cycle index and trigger monitor (sampled on the falling edge).
  int   cyc = 0, trig_total = 0, rises = 0, last_rise = -1;
  logic trig_prev = 1'b0;
  always @(posedge adc_clk_i) cyc <= cyc + 1;
  always @(negedge adc_clk_i) begin
    if (sort_trig_o) begin
      trig_total <= trig_total + 1;
      if (!trig_prev) begin
        rises     <= rises + 1;
        last_rise <= cyc;
      end
    end
    trig_prev <= sort_trig_o;
  end

  int n_checks = 0, n_fail = 0;
  int drops = 0, sorts = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk_i);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    tick();
    check("wr_ack", sys_ack, 1);
    sys_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sys_addr = a; sys_ren = 1'b1;
    tick();
    check("rd_ack", sys_ack, 1);
    d = sys_rdata;
    sys_ren = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Samples above threshold for w cycles, with the peak in the middle.
  task automatic drive_drop(input int w, input int pk);
    for (int i = 0; i < w; i++) begin
      adc_a_i = (i == w / 2) ? DW'(pk) : DW'(300);
      tick();
    end
    adc_a_i = '0;
  endtask

  task automatic check_stats(input string tag);
`ifdef FADS_STATS_EN
    read_check({tag, "_droplet_cnt"}, 32'h24, drops);
    read_check({tag, "_sorted_cnt"}, 32'h28, sorts);
`else
    read_check({tag, "_cnt_absent"}, 32'h24, 0);
`endif
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] wd; logic [31:0] rexp; } reg_vec_t;
  typedef struct { int w; int pk; int dly; int pls; int hld; bit sort; } drop_vec_t;

  reg_vec_t  rv[13];
  drop_vec_t dv[9];

  initial begin
    int n0, t0, r0, n;

    rv[0]  = '{32'h04, 32'hFFFF_FFFF, 32'h0000_3FFF};
    rv[1]  = '{32'h08, 32'h0001_2345, 32'h0000_2345};
    rv[2]  = '{32'h0C, 32'hABCD_1234, 32'h0000_1234};
    rv[3]  = '{32'h10, 32'hFFFF_FFFF, 32'h0000_FFFF};
    rv[4]  = '{32'h14, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    rv[5]  = '{32'h14, 32'h00A5_A5A5, 32'h00A5_A5A5};
    rv[6]  = '{32'h18, 32'h0001_0007, 32'h0000_0007};
    rv[7]  = '{32'h1C, 32'h0000_BEEF, 32'h0000_BEEF};
    rv[8]  = '{32'h00, 32'h0000_0003, 32'h0000_0001};
    rv[9]  = '{32'h00, 32'h0000_0000, 32'h0000_0000};
    rv[10] = '{32'h20, 32'hFFFF_FFFF, 32'h0000_0000};
    rv[11] = '{32'h24, 32'h1234_5678, 32'h0000_0000};
    rv[12] = '{32'h40, 32'hFFFF_FFFF, 32'h0000_0000};

    dv[0] = '{8,  500,  10, 4, 5, 1'b1};
    dv[1] = '{8,  1200, 10, 4, 5, 1'b0};
    dv[2] = '{4,  500,  10, 4, 5, 1'b0};
    dv[3] = '{21, 500,  10, 4, 5, 1'b0};
    dv[4] = '{5,  500,  10, 4, 5, 1'b1};
    dv[5] = '{20, 500,  10, 4, 5, 1'b1};
    dv[6] = '{8,  1000, 10, 4, 5, 1'b0};
    dv[7] = '{6,  500,  0,  0, 0, 1'b1};
    dv[8] = '{7,  999,  3,  1, 2, 1'b1};

    // Reset state
    repeat (4) tick();
    adc_rst_i = 1'b0;
    tick();
    check("rst_trig", sort_trig_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ack", sys_ack, 0);
    check("rst_rdata", sys_rdata, 0);
    check("rst_err", sys_err, 0);

    // Ack arrives one cycle after the strobe
    sys_addr = 32'h18; sys_ren = 1'b1;
    #1;
    check("ack_same_cycle", sys_ack, 0);
    tick();
    check("ack_next_cycle", sys_ack, 1);
    check("rst_pulse_len", sys_rdata, 1);
    sys_ren = 1'b0;
    tick();
    check("ack_drop", sys_ack, 0);
    read_check("rst_status", 32'h20, 0);
    read_check("rst_delay", 32'h14, 0);

    // Register write/readback table
    for (int i = 0; i < 13; i++) begin
      bus_write(rv[i].addr, rv[i].wd);
      read_check($sformatf("reg_rb[%0d]", i), rv[i].addr, rv[i].rexp);
    end

    // Sorting configuration
    bus_write(32'h04, 100);
    bus_write(32'h08, 1000);
    bus_write(32'h0C, 5);
    bus_write(32'h10, 20);
    bus_write(32'h00, 1);
    repeat (3) tick();
    read_check("armed_idle", 32'h20, 1);

    // Droplet table
    for (int i = 0; i < 9; i++) begin
      bus_write(32'h14, dv[i].dly);
      bus_write(32'h18, dv[i].pls);
      bus_write(32'h1C, dv[i].hld);
      t0 = trig_total; r0 = rises;
      n0 = cyc;
      drive_drop(dv[i].w, dv[i].pk);
      wait_until(n0 + 70);
      check($sformatf("trig_cycles[%0d]", i), trig_total - t0,
            dv[i].sort ? ((dv[i].pls == 0) ? 1 : dv[i].pls) : 0);
      check($sformatf("trig_pulses[%0d]", i), rises - r0, dv[i].sort ? 1 : 0);
      if (dv[i].sort)
        check($sformatf("trig_start[%0d]", i), last_rise, n0 + dv[i].w + 3 + dv[i].dly);
      check($sformatf("busy_end[%0d]", i), busy_o, 0);
      read_check($sformatf("status_end[%0d]", i), 32'h20, 1);
      drops++;
      if (dv[i].sort) sorts++;
      check_stats($sformatf("drop%0d", i));
`ifdef FADS_STATS_EN
      read_check($sformatf("last_width[%0d]", i), 32'h2C, dv[i].w);
      read_check($sformatf("last_peak[%0d]", i), 32'h30, dv[i].pk);
`endif
    end

    // Droplets during DELAY and HOLD are ignored
    bus_write(32'h14, 20);
    bus_write(32'h18, 2);
    bus_write(32'h1C, 10);
    t0 = trig_total; r0 = rises;
    n0 = cyc;
    drive_drop(8, 500);
    wait_until(n0 + 14);
    drive_drop(6, 500);
    wait_until(n0 + 33);
    drive_drop(4, 500);
    wait_until(n0 + 60);
    check("ignore_trig_cycles", trig_total - t0, 2);
    check("ignore_trig_pulses", rises - r0, 1);
    check("ignore_trig_start", last_rise, n0 + 31);
    drops++; sorts++;
    check_stats("ignore");

    // Enabling mid-droplet must wait for the signal to drop
    bus_write(32'h00, 0);
    adc_a_i = DW'(400);
    repeat (3) tick();
    bus_write(32'h00, 1);
    r0 = rises;
    repeat (10) tick();
    check("middrop_busy", busy_o, 0);
    read_check("middrop_arm", 32'h20, 0);
    adc_a_i = '0;
    repeat (3) tick();
    read_check("middrop_idle", 32'h20, 1);
    check("middrop_no_trig", rises - r0, 0);
    check_stats("middrop");

    // Clearing enable during FIRE
    bus_write(32'h14, 2);
    bus_write(32'h18, 10);
    bus_write(32'h1C, 3);
    t0 = trig_total;
    drive_drop(8, 500);
    n = 0;
    while (!sort_trig_o && n < 50) begin
      tick();
      n++;
    end
    check("fire_seen", sort_trig_o, 1);
    bus_write(32'h00, 0);
    check("fire_still_high", sort_trig_o, 1);
    tick();
    check("disable_trig_low", sort_trig_o, 0);
    check("disable_busy_low", busy_o, 0);
    check("disable_trig_cycles", trig_total - t0, 2);
    read_check("disable_state_arm", 32'h20, 0);
    drops++; sorts++;
    check_stats("disable");
    bus_write(32'h00, 1);
    repeat (3) tick();

`ifdef FADS_STATS_EN
    // Counter clear coinciding with EVAL
    bus_write(32'h14, 1);
    bus_write(32'h18, 1);
    bus_write(32'h1C, 1);
    n0 = cyc;
    drive_drop(8, 500);
    wait_until(n0 + 9);
    bus_write(32'h00, 3);
    wait_until(n0 + 30);
    check("clr_trig_start", last_rise, n0 + 12);
    drops = 0; sorts = 1;
    check_stats("clr_eval");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
